// File: rtl/tx_pkg.sv
// Shared types and sizing for the TX slot drain path.
package tx_pkg;

  localparam int size_width_lp     = 16;
  localparam int slot_bytes_lp     = 2048;
  localparam int max_data_width_lp = 64;
  localparam int max_keep_width_lp = max_data_width_lp / 8;

  typedef enum logic {
    IDLE_S   = 1'b0,
    STREAM_S = 1'b1
  } state_e;

  // Sized for the widest word; narrower instances use the low bits.
  typedef struct packed {
    logic [max_data_width_lp-1:0] data;
    logic [max_keep_width_lp-1:0] keep;
    logic                         last;
  } tx_beat_s;

endpackage

// File: rtl/tx_frame_reader_fifo.sv
// Two-entry beat FIFO; the head entry drives the outputs straight from a register.
module tx_frame_reader_fifo
  import tx_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       v_i,
  input  tx_beat_s   data_i,
  output logic       v_o,
  output tx_beat_s   data_o,
  input  logic       yumi_i,
  output logic [1:0] count_o
);

  tx_beat_s   mem_q [2];
  tx_beat_s   mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  // The producer only writes when space is guaranteed, so push is never refused.
  always_comb begin
    push     = v_i;
    pop      = yumi_i && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/tx_frame_reader.sv
// Drains committed TX slots from buffer memory and streams them to the MAC as
// keep/last beats, releasing each slot once its final word read is issued.
module tx_frame_reader
  import tx_pkg::*;
#(
  parameter  int data_width_p  = 64,
  parameter  int els_p         = slot_bytes_lp,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int keep_width_lp = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     read_slot_v_i,
  output logic                     read_slot_ready_and_o,
  input  logic [size_width_lp-1:0] read_size_i,
  output logic                     read_v_o,
  output logic [addr_width_lp-1:0] read_addr_o,
  input  logic [data_width_p-1:0]  read_data_i,
  output logic                     tx_v_o,
  input  logic                     tx_ready_i,
  output logic [data_width_p-1:0]  tx_data_o,
  output logic [keep_width_lp-1:0] tx_keep_o,
  output logic                     tx_last_o,
  output logic                     size_err_o,
  output logic                     dbg_state_o
);

  localparam int lsb_lp       = $clog2(keep_width_lp);
  localparam int cnt_width_lp = size_width_lp + 1;
  localparam logic [cnt_width_lp-1:0] els_lp   = cnt_width_lp'(els_p);
  localparam logic [cnt_width_lp-1:0] round_lp = cnt_width_lp'(keep_width_lp - 1);

  state_e                    state_q, state_d;
  logic [cnt_width_lp-1:0]   idx_q, idx_d;
  logic [cnt_width_lp-1:0]   last_idx_q, last_idx_d;
  logic [lsb_lp-1:0]         rem_q, rem_d;
  logic                      infl_q, infl_d;
  logic                      infl_last_q, infl_last_d;
  logic [keep_width_lp-1:0]  infl_keep_q, infl_keep_d;
  logic                      size_err_q, size_err_d;

  logic [cnt_width_lp-1:0]   size_c, words;
  logic [keep_width_lp-1:0]  keep_rem;
  logic [1:0]                fifo_count, occ;
  logic                      fifo_v, tx_hs, credit_ok, issue, last_issue;
  tx_beat_s                  fifo_in, fifo_out;

  // All handshakes are valid/ready: a transfer happens in a cycle where both
  // sides are high; valid never waits on ready, and the slot is dequeued by
  // read_slot_ready_and_o on the cycle its last word read is issued.
  always_comb begin
    tx_hs      = fifo_v && tx_ready_i;
    occ        = fifo_count + {1'b0, infl_q};
    credit_ok  = (occ < 2'd2) || ((occ == 2'd2) && tx_hs);
    issue      = (state_q == STREAM_S) && credit_ok;
    last_issue = issue && (idx_q == last_idx_q);
    for (int b = 0; b < keep_width_lp; b++) begin
      keep_rem[b] = (b < int'(rem_q));
    end

    state_d               = state_q;
    idx_d                 = idx_q;
    last_idx_d            = last_idx_q;
    rem_d                 = rem_q;
    size_err_d            = 1'b0;
    read_slot_ready_and_o = 1'b0;
    size_c                = cnt_width_lp'(read_size_i);
    words                 = '0;
    infl_d                = issue;
    infl_last_d           = last_issue;
    infl_keep_d           = (last_issue && (rem_q != '0)) ? keep_rem : '1;

    case (state_q)
      IDLE_S: begin
        if (read_slot_v_i) begin
          idx_d = '0;
          if (size_c == '0) begin
            read_slot_ready_and_o = 1'b1;
            size_err_d            = 1'b1;
          end else begin
            if (size_c > els_lp) begin
              size_err_d = 1'b1;
              size_c     = els_lp;
            end
            words      = (size_c + round_lp) >> lsb_lp;
            last_idx_d = words - cnt_width_lp'(1);
            rem_d      = size_c[lsb_lp-1:0];
            state_d    = STREAM_S;
          end
        end
      end
      STREAM_S: begin
        if (issue) begin
          idx_d = idx_q + cnt_width_lp'(1);
        end
        if (last_issue) begin
          read_slot_ready_and_o = read_slot_v_i;
          state_d               = IDLE_S;
        end
      end
      default: state_d = IDLE_S;
    endcase

    read_v_o    = issue;
    read_addr_o = issue ? addr_width_lp'(idx_q << lsb_lp) : '0;

    fifo_in      = '0;
    fifo_in.data = max_data_width_lp'(read_data_i);
    fifo_in.keep = max_keep_width_lp'(infl_keep_q);
    fifo_in.last = infl_last_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE_S;
      idx_q       <= '0;
      last_idx_q  <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_keep_q <= '0;
      size_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      infl_keep_q <= infl_keep_d;
      size_err_q  <= size_err_d;
    end
  end

  tx_frame_reader_fifo u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (infl_q),
    .data_i    (fifo_in),
    .v_o       (fifo_v),
    .data_o    (fifo_out),
    .yumi_i    (tx_hs),
    .count_o   (fifo_count)
  );

  assign tx_v_o      = fifo_v;
  assign tx_data_o   = fifo_out.data[data_width_p-1:0];
  assign tx_keep_o   = fifo_out.keep[keep_width_lp-1:0];
  assign tx_last_o   = fifo_out.last;
  assign size_err_o  = size_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tx_frame_reader.sv
// Randomized bench for tx_frame_reader: slot driver, memory responder, MAC sink
// and a frame-level reference model feeding an expected-beat queue.
module tb_tx_frame_reader;

  localparam int bw_lp = 73;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n_i     = 1'b0;
  logic        read_slot_v_i = 1'b0;
  logic        read_slot_ready_and_o;
  logic [15:0] read_size_i   = '0;
  logic        read_v_o;
  logic [10:0] read_addr_o;
  logic [63:0] read_data_i   = '0;
  logic        tx_v_o;
  logic        tx_ready_i    = 1'b1;
  logic [63:0] tx_data_o;
  logic [7:0]  tx_keep_o;
  logic        tx_last_o;
  logic        size_err_o;
  logic        dbg_state_o;

  tx_frame_reader #(.data_width_p(64), .els_p(2048)) dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n_i),
    .read_slot_v_i         (read_slot_v_i),
    .read_slot_ready_and_o (read_slot_ready_and_o),
    .read_size_i           (read_size_i),
    .read_v_o              (read_v_o),
    .read_addr_o           (read_addr_o),
    .read_data_i           (read_data_i),
    .tx_v_o                (tx_v_o),
    .tx_ready_i            (tx_ready_i),
    .tx_data_o             (tx_data_o),
    .tx_keep_o             (tx_keep_o),
    .tx_last_o             (tx_last_o),
    .size_err_o            (size_err_o),
    .dbg_state_o           (dbg_state_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [bw_lp-1:0] exp_q[$];
  logic [31:0]      seed_q[$];

  function automatic logic [63:0] word_val(input logic [31:0] seed, input int addr);
    logic [31:0] a;
    a = 32'(addr);
    return {seed ^ (a * 32'h9E3779B9), seed + a};
  endfunction

  function automatic int frame_beats(input int size);
    int eff;
    eff = (size > 2048) ? 2048 : size;
    return (eff + 7) / 8;
  endfunction

  task automatic model_add(input int size, input logic [31:0] seed);
    int eff, nw, r;
    logic [7:0] keep;
    eff = (size > 2048) ? 2048 : size;
    nw  = frame_beats(size);
    for (int w = 0; w < nw; w++) begin
      r    = (w == nw - 1) ? (eff % 8) : 0;
      keep = (r == 0) ? 8'hFF : 8'((1 << r) - 1);
      exp_q.push_back({(w == nw - 1), keep, word_val(seed, w * 8)});
    end
  endtask

  // ---------------- monitors / responder ----------------
  int rd_cyc_q[$];
  int rd_addr_q[$];
  int deq_cyc_q[$];
  int err_cnt, beat_cnt, txv_cnt, first_tx_cyc;
  int issued, accepted;
  bit rand_ready = 1'b0;
  bit stall_prev = 1'b0;
  bit pend_v     = 1'b0;
  logic [63:0]      pend_data;
  logic [bw_lp-1:0] prev_beat;

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic log_clear();
    rd_cyc_q.delete();
    rd_addr_q.delete();
    deq_cyc_q.delete();
    err_cnt = 0; beat_cnt = 0; txv_cnt = 0; first_tx_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (!reset_n_i) begin
      stall_prev = 1'b0; pend_v = 1'b0; issued = 0; accepted = 0;
    end else begin
      if (stall_prev)
        check("stall_hold", {tx_v_o, tx_last_o, tx_keep_o, tx_data_o}, {1'b1, prev_beat});
      if (read_v_o) begin
        check("credit", ((issued - accepted) < 2) ||
              (((issued - accepted) == 2) && tx_v_o && tx_ready_i), 1);
        rd_cyc_q.push_back(cyc);
        rd_addr_q.push_back(int'(read_addr_o));
        pend_data = (seed_q.size() > 0) ? word_val(seed_q[0], int'(read_addr_o)) : 64'hBAD0_BAD0_BAD0_BAD0;
      end
      pend_v = read_v_o;
      if (read_slot_ready_and_o) begin
        check("deq_needs_valid", read_slot_v_i, 1);
        deq_cyc_q.push_back(cyc);
        if (seed_q.size() > 0) void'(seed_q.pop_front());
      end
      if (size_err_o) err_cnt++;
      if (tx_v_o) begin
        txv_cnt++;
        if (first_tx_cyc < 0) first_tx_cyc = cyc;
      end
      if (tx_v_o && tx_ready_i) begin
        beat_cnt++;
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("beat", {tx_last_o, tx_keep_o, tx_data_o}, exp_q.pop_front());
      end
      issued   += int'(read_v_o);
      accepted += int'(tx_v_o && tx_ready_i);
      stall_prev = tx_v_o && !tx_ready_i;
      prev_beat  = {tx_last_o, tx_keep_o, tx_data_o};
    end
  end

  // Synchronous memory: data for a read issued in cycle c is valid in cycle c+1.
  always @(posedge clk) begin
    #1;
    read_data_i = pend_v ? pend_data : {$urandom, $urandom};
  end

  always @(posedge clk) begin
    #1;
    tx_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic present_slot(input int size, input logic [31:0] seed);
    bit hs;
    int n;
    hs = 1'b0; n = 0;
    model_add(size, seed);
    seed_q.push_back(seed);
    read_slot_v_i = 1'b1;
    read_size_i   = 16'(size);
    while (!hs && n < 6000) begin
      @(negedge clk);
      hs = read_slot_ready_and_o;
      @(posedge clk); #1;
      n++;
    end
    check("slot_deq", hs, 1);
    read_slot_v_i = 1'b0;
    read_size_i   = 16'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_v_o) && n < 8000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_read_v"}, read_v_o, 0);
    check({tag, "_slot_ready"}, read_slot_ready_and_o, 0);
    check({tag, "_tx_v"}, tx_v_o, 0);
    check({tag, "_tx_last"}, tx_last_o, 0);
    check({tag, "_size_err"}, size_err_o, 0);
    check({tag, "_tx_keep"}, tx_keep_o, 0);
    check({tag, "_tx_data"}, tx_data_o, 0);
    check({tag, "_read_addr"}, read_addr_o, 0);
    check({tag, "_state"}, dbg_state_o, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int c0, total_beats, total_err, sz;
    logic [31:0] s;
    log_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n_i = 1'b1;
    @(posedge clk); #1;

    // Size 20: latency, addresses, keep and dequeue timing.
    log_clear(); c0 = cyc;
    present_slot(20, $urandom);
    wait_drain();
    check("s20_first_read", qat(rd_cyc_q, 0) - c0, 1);
    check("s20_first_tx", first_tx_cyc - c0, 3);
    check("s20_deq_cycle", qat(deq_cyc_q, 0) - c0, 3);
    check("s20_reads", rd_cyc_q.size(), 3);
    check("s20_addr0", qat(rd_addr_q, 0), 0);
    check("s20_addr1", qat(rd_addr_q, 1), 8);
    check("s20_addr2", qat(rd_addr_q, 2), 16);
    check("s20_beats", beat_cnt, 3);

    log_clear(); present_slot(16, $urandom); wait_drain();
    check("s16_beats", beat_cnt, 2);
    log_clear(); present_slot(1, $urandom); wait_drain();
    check("s1_beats", beat_cnt, 1);

    // 1500 bytes under random backpressure.
    log_clear(); rand_ready = 1'b1;
    present_slot(1500, $urandom); wait_drain();
    rand_ready = 1'b0;
    check("s1500_beats", beat_cnt, 188);
    check("s1500_reads", rd_cyc_q.size(), 188);

    // Back-to-back 64 then 9.
    log_clear();
    present_slot(64, $urandom);
    present_slot(9, $urandom);
    wait_drain();
    check("b2b_reads", rd_cyc_q.size(), 10);
    check("b2b_a_stream", qat(rd_cyc_q, 7) - qat(rd_cyc_q, 0), 7);
    check("b2b_gap", qat(rd_cyc_q, 8) - qat(rd_cyc_q, 7), 2);
    check("b2b_b_addr0", qat(rd_addr_q, 8), 0);
    check("b2b_b_addr1", qat(rd_addr_q, 9), 8);
    check("b2b_beats", beat_cnt, 10);

    // Zero-length slot.
    log_clear(); c0 = cyc;
    present_slot(0, $urandom); wait_drain();
    check("s0_err", err_cnt, 1);
    check("s0_deq_cycle", qat(deq_cyc_q, 0) - c0, 0);
    check("s0_tx_v", txv_cnt, 0);
    check("s0_reads", rd_cyc_q.size(), 0);

    // Oversize slot clamps to capacity.
    log_clear();
    present_slot(3000, $urandom); wait_drain();
    check("s3000_err", err_cnt, 1);
    check("s3000_beats", beat_cnt, 256);
    check("s3000_last_addr", qat(rd_addr_q, 255), 2040);

    // Reset in the middle of a frame.
    log_clear(); rand_ready = 1'b1;
    s = $urandom;
    model_add(1500, s);
    seed_q.push_back(s);
    read_slot_v_i = 1'b1;
    read_size_i   = 16'd1500;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_pending", (exp_q.size() > 0) && (exp_q.size() < 188), 1);
    reset_n_i     = 1'b0;
    read_slot_v_i = 1'b0;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    seed_q.delete();
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    log_clear();
    present_slot(8, $urandom); wait_drain();
    check("post_rst_beats", beat_cnt, 1);

    // Random frames, presented back-to-back under backpressure.
    log_clear(); rand_ready = 1'b1;
    total_beats = 0; total_err = 0;
    for (int i = 0; i < 6; i++) begin
      sz = $urandom_range(1, 2100);
      total_beats += frame_beats(sz);
      total_err   += int'(sz > 2048);
      present_slot(sz, $urandom);
    end
    wait_drain();
    rand_ready = 1'b0;
    check("rand_beats", beat_cnt, total_beats);
    check("rand_err", err_cnt, total_err);
    check("final_idle", tx_v_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
